// File: rtl/n64_transmit_frame.sv
// Joybus frame transmitter: streams 1..MAX_BYTES payload bytes MSB-first onto n64d, then a stop bit.
// Optional N64_TX_CRC_EN appends the pak-data CRC-8 (poly 0x85) after a properly terminated payload.
module n64_transmit_frame #(
    parameter int UNIT_TICKS = 50,
    parameter int MAX_BYTES  = 36,
    parameter int CNT_W      = 8
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    input  logic             tx_last,
    output logic             tx_ready,
    output logic             n64d,
    output logic             transmitting,
    output logic             done,
    output logic             underrun,
    output logic [CNT_W-1:0] byte_count
);
    localparam int TICK_W = $clog2(3 * UNIT_TICKS + 1);
    localparam logic [TICK_W-1:0] LEN1 = TICK_W'(UNIT_TICKS - 1);
    localparam logic [TICK_W-1:0] LEN2 = TICK_W'(2 * UNIT_TICKS - 1);
    localparam logic [TICK_W-1:0] LEN3 = TICK_W'(3 * UNIT_TICKS - 1);
    localparam logic [CNT_W+1:0]  MAX_C = (CNT_W + 2)'(MAX_BYTES);
    localparam logic [CNT_W+1:0]  ONE_C = (CNT_W + 2)'(1);
    localparam logic [CNT_W+1:0]  TWO_C = (CNT_W + 2)'(2);

    typedef enum logic [2:0] {IDLE, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH} state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        hold_q, hold_d;
    logic              shift_last_q, shift_last_d;
    logic              hold_last_q, hold_last_d;
    logic              hold_full_q, hold_full_d;
    logic              n64d_q, n64d_d;
    logic              transmitting_q, transmitting_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [TICK_W-1:0] phase_end;
    logic [CNT_W+1:0]  count_ext;
    logic              phase_done;
    logic              byte_end;
    logic              xfer;
    logic              in_bits;
    logic              sending_crc;

`ifdef N64_TX_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic       crc_phase_q, crc_phase_d;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ 8'h85;
            else                c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign sending_crc = crc_phase_q;
`else
    assign sending_crc = 1'b0;
`endif

    always_comb begin
        count_ext = {2'b00, count_q};
        in_bits   = (state_q == BIT_LOW) || (state_q == BIT_HIGH);
        case (state_q)
            BIT_LOW:   phase_end = shift_q[7] ? LEN1 : LEN3;
            BIT_HIGH:  phase_end = shift_q[7] ? LEN3 : LEN1;
            STOP_HIGH: phase_end = LEN2;
            default:   phase_end = LEN1;
        endcase
        phase_done = (tick_q == phase_end);
        byte_end   = (state_q == BIT_HIGH) && phase_done && (bit_q == 3'd7);
        xfer       = byte_end && !sending_crc && !shift_last_q &&
                     (count_ext + ONE_C != MAX_C) && hold_full_q;

        // A refill is allowed only if the byte it would carry still fits in the frame.
        tx_ready = 1'b0;
        if (state_q == IDLE)
            tx_ready = 1'b1;
        else if (in_bits && xfer)
            tx_ready = !hold_last_q && (count_ext + TWO_C < MAX_C);
        else if (in_bits)
            tx_ready = !hold_full_q && !shift_last_q && !sending_crc &&
                       (count_ext + ONE_C < MAX_C);
    end

    always_comb begin
        state_d        = state_q;
        tick_d         = tick_q;
        bit_d          = bit_q;
        shift_d        = shift_q;
        hold_d         = hold_q;
        shift_last_d   = shift_last_q;
        hold_last_d    = hold_last_q;
        hold_full_d    = hold_full_q;
        n64d_d         = n64d_q;
        transmitting_d = transmitting_q;
        done_d         = 1'b0;
        underrun_d     = underrun_q;
        count_d        = count_q;
`ifdef N64_TX_CRC_EN
        crc_d          = crc_q;
        crc_phase_d    = crc_phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shift_d        = tx_data;
                    shift_last_d   = tx_last;
                    hold_full_d    = 1'b0;
                    transmitting_d = 1'b1;
                    underrun_d     = 1'b0;
                    count_d        = '0;
                    tick_d         = '0;
                    bit_d          = 3'd0;
                    n64d_d         = 1'b0;
                    state_d        = BIT_LOW;
`ifdef N64_TX_CRC_EN
                    crc_d          = crc8_byte(8'h00, tx_data);
                    crc_phase_d    = 1'b0;
`endif
                end
            end
            BIT_LOW: begin
                if (phase_done) begin
                    tick_d  = '0;
                    n64d_d  = 1'b1;
                    state_d = BIT_HIGH;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            BIT_HIGH: begin
                if (!phase_done) begin
                    tick_d = tick_q + 1'b1;
                end else begin
                    tick_d = '0;
                    n64d_d = 1'b0;
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {shift_q[6:0], 1'b0};
                        state_d = BIT_LOW;
                    end else begin
                        bit_d = 3'd0;
                        if (sending_crc) begin
                            state_d = STOP_LOW;
                        end else begin
                            count_d = count_q + 1'b1;
                            if (shift_last_q) begin
`ifdef N64_TX_CRC_EN
                                shift_d     = crc_q;
                                crc_phase_d = 1'b1;
                                state_d     = BIT_LOW;
`else
                                state_d     = STOP_LOW;
`endif
                            end else if (count_ext + ONE_C == MAX_C) begin
                                state_d = STOP_LOW;
                            end else if (hold_full_q) begin
                                shift_d      = hold_q;
                                shift_last_d = hold_last_q;
                                hold_full_d  = 1'b0;
                                state_d      = BIT_LOW;
`ifdef N64_TX_CRC_EN
                                crc_d        = crc8_byte(crc_q, hold_q);
`endif
                            end else begin
                                underrun_d = 1'b1;
                                state_d    = STOP_LOW;
                            end
                        end
                    end
                end
            end
            STOP_LOW: begin
                if (phase_done) begin
                    tick_d  = '0;
                    n64d_d  = 1'b1;
                    state_d = STOP_HIGH;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            STOP_HIGH: begin
                if (phase_done) begin
                    tick_d         = '0;
                    transmitting_d = 1'b0;
                    done_d         = 1'b1;
                    hold_full_d    = 1'b0;
                    state_d        = IDLE;
`ifdef N64_TX_CRC_EN
                    crc_phase_d    = 1'b0;
`endif
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Refill after the transfer so a same-cycle handshake wins over the clear.
        if (in_bits && tx_valid && tx_ready) begin
            hold_d      = tx_data;
            hold_last_d = tx_last;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            tick_q         <= '0;
            bit_q          <= 3'd0;
            shift_q        <= 8'h00;
            hold_q         <= 8'h00;
            shift_last_q   <= 1'b0;
            hold_last_q    <= 1'b0;
            hold_full_q    <= 1'b0;
            n64d_q         <= 1'b1;
            transmitting_q <= 1'b0;
            done_q         <= 1'b0;
            underrun_q     <= 1'b0;
            count_q        <= '0;
`ifdef N64_TX_CRC_EN
            crc_q          <= 8'h00;
            crc_phase_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            tick_q         <= tick_d;
            bit_q          <= bit_d;
            shift_q        <= shift_d;
            hold_q         <= hold_d;
            shift_last_q   <= shift_last_d;
            hold_last_q    <= hold_last_d;
            hold_full_q    <= hold_full_d;
            n64d_q         <= n64d_d;
            transmitting_q <= transmitting_d;
            done_q         <= done_d;
            underrun_q     <= underrun_d;
            count_q        <= count_d;
`ifdef N64_TX_CRC_EN
            crc_q          <= crc_d;
            crc_phase_q    <= crc_phase_d;
`endif
        end
    end

    assign n64d         = n64d_q;
    assign transmitting = transmitting_q;
    assign done         = done_q;
    assign underrun     = underrun_q;
    assign byte_count   = count_q;

endmodule

// File: tb/tb_n64_transmit_frame.sv
// Scoreboarded bench for n64_transmit_frame: line waveform decoded back into bytes and checked.
module tb_n64_transmit_frame;
    localparam int UT = 4;
    localparam int MB = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_valid = 1'b0;
    logic          tx_last = 1'b0;
    logic          tx_ready;
    logic          n64d;
    logic          transmitting;
    logic          done;
    logic          underrun;
    logic [CW-1:0] byte_count;

    always #5 clk = ~clk;

    n64_transmit_frame #(.UNIT_TICKS(UT), .MAX_BYTES(MB), .CNT_W(CW)) dut (
        .sys_clk(clk), .reset(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .n64d(n64d), .transmitting(transmitting), .done(done),
        .underrun(underrun), .byte_count(byte_count)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    int exp_cnt_q[$];
    int exp_und_q[$];
    int exp_byte_q[$];
    logic [7:0] fb [8];

    // Monitor: run-length decode of the line, compared against the scoreboard on each done pulse.
    int lo = 0, hi = 0, nbits = 0, tx_cycles = 0;
    logic [7:0] cur = 8'h00;
    int got_bytes[$];

    always @(negedge clk) begin
        if (rst) begin
            lo = 0; hi = 0; nbits = 0; tx_cycles = 0;
            got_bytes.delete();
        end else if (done) begin
            int m, u, e, g;
            chk("stop_low_len", lo, UT);
            chk("stop_high_len", hi, 2 * UT);
            chk("partial_bits", nbits, 0);
            chk("frame_pending", int'(exp_cnt_q.size() > 0), 1);
            if (exp_cnt_q.size() > 0) begin
                m = exp_cnt_q.pop_front();
                u = exp_und_q.pop_front();
                chk("bytes_on_line", got_bytes.size(), m);
                chk("byte_count", byte_count, m);
                chk("underrun", underrun, u);
                chk("frame_len", tx_cycles, m * 8 * 4 * UT + 3 * UT);
                for (int i = 0; i < m; i++) begin
                    e = exp_byte_q.pop_front();
                    g = (i < got_bytes.size()) ? got_bytes[i] : -1;
                    chk("byte_value", g, e);
                end
            end
            lo = 0; hi = 0; nbits = 0; tx_cycles = 0;
            got_bytes.delete();
        end else begin
            if (transmitting) tx_cycles++;
            if (n64d == 1'b0) begin
                if (hi > 0) begin
                    logic b;
                    b = (lo == UT && hi == 3 * UT);
                    chk("pulse_shape", int'((lo == UT && hi == 3 * UT) || (lo == 3 * UT && hi == UT)), 1);
                    cur = {cur[6:0], b};
                    nbits++;
                    if (nbits == 8) begin
                        got_bytes.push_back(int'(cur));
                        nbits = 0;
                    end
                    lo = 0; hi = 0;
                end
                lo++;
            end else if (lo > 0) begin
                hi++;
            end
        end
    end

    // Source: offers fb[0..n_off-1]; optional reset abort at a given cycle of the frame.
    task automatic run_frame(input int n_off, input int has_last, input int abort_at);
        int m, und, acc, gap, finished;
        bit hs;
        m = 0; und = 0;
        for (int i = 0; i < n_off; i++) begin
            m = i + 1;
            if (has_last != 0 && i == n_off - 1) break;
            if (m == MB) break;
            if (i == n_off - 1) begin und = 1; break; end
        end
        if (abort_at == 0) begin
            exp_cnt_q.push_back(m);
            exp_und_q.push_back(und);
            for (int i = 0; i < m; i++) exp_byte_q.push_back(int'(fb[i]));
        end
        acc = 0; gap = 0; hs = 1'b0; finished = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (hs) begin
                acc++;
                tx_valid = 1'b0;
                gap = $urandom_range(0, 2);
            end
            if (abort_at != 0 && cyc == abort_at) begin
                chk("pre_reset_low", n64d, 0);
                rst = 1'b1;
                tx_valid = 1'b0;
                #1;
                chk("reset_n64d", n64d, 1);
                chk("reset_transmitting", transmitting, 0);
                chk("reset_ready", tx_ready, 1);
                chk("reset_byte_count", byte_count, 0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                finished = 1;
                break;
            end
            if (done) begin
                tx_valid = 1'b0;
                chk("bytes_accepted", acc, m);
                finished = 1;
                break;
            end
            if (acc < n_off && !tx_valid) begin
                if (gap > 0) gap--;
                else begin
                    tx_data  = fb[acc];
                    tx_last  = (has_last != 0) && (acc == n_off - 1);
                    tx_valid = 1'b1;
                end
            end
            hs = tx_valid && tx_ready;
        end
        chk("frame_completed", finished, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_n64d", n64d, 1);
        chk("rst_transmitting", transmitting, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_byte_count", byte_count, 0);
        chk("rst_tx_ready", tx_ready, 1);

        fb[0] = 8'h80;
        run_frame(1, 1, 0);
        fb[0] = 8'h00; fb[1] = 8'h00; fb[2] = 8'h12; fb[3] = 8'h34;
        run_frame(4, 1, 0);
        fb[0] = 8'hA5;
        run_frame(1, 0, 0);
        chk("underrun_sticky_idle", underrun, 1);
        for (int i = 0; i < 6; i++) fb[i] = 8'(8'h31 + i);
        run_frame(6, 0, 0);
        fb[0] = 8'hC3; fb[1] = 8'h00; fb[2] = 8'h5A;
        run_frame(3, 1, 133);
        fb[0] = 8'h6E; fb[1] = 8'h01;
        run_frame(2, 1, 0);

        for (int f = 0; f < 20; f++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) fb[i] = 8'($urandom_range(0, 255));
            run_frame(n, int'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_cnt_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
